// File: rtl/psola_pkg.sv
// Shared constants and types for the PSOLA playback path.
// Bank geometry, the Q.10 scaling of the accumulator, and the 16-bit output limits.
package psola_pkg;

  localparam int WINDOW_SIZE = 2048;
  localparam int FRAC_BITS   = 10;
  localparam int ADDR_W      = $clog2(WINDOW_SIZE) + 1;

  localparam logic signed [15:0] SAMPLE_MAX = 16'sh7fff;
  localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT1,
    ST_WAIT2,
    ST_EMIT
  } play_state_e;

endpackage

// File: rtl/psola_playback_if.sv
// Port bundle between the playback block and the ping-pong output BRAM.
// The read port has two cycles of latency; the clear port always writes zero.
interface psola_playback_if;
  import psola_pkg::*;

  logic [ADDR_W:0] rd_addr_out;
  logic [31:0]     rd_data_in;
  logic [ADDR_W:0] clr_addr_out;
  logic            clr_we_out;

  modport master (output rd_addr_out, output clr_addr_out, output clr_we_out, input rd_data_in);
  modport slave  (input rd_addr_out, input clr_addr_out, input clr_we_out, output rd_data_in);

endinterface

// File: rtl/psola_playback_q_sat_shift.sv
// Arithmetic right shift of a Q-format accumulator followed by signed 16-bit saturation.
// Purely combinational so gain stages can chain it freely.
module q_sat_shift
  import psola_pkg::*;
#(
  parameter int SHIFT = FRAC_BITS
) (
  input  logic signed [31:0] acc,
  output logic signed [15:0] sat
);

  localparam logic signed [31:0] WIDE_MAX = 32'(SAMPLE_MAX);
  localparam logic signed [31:0] WIDE_MIN = 32'(SAMPLE_MIN);

  logic signed [31:0] shifted;

  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted > WIDE_MAX)
      sat = SAMPLE_MAX;
    else if (shifted < WIDE_MIN)
      sat = SAMPLE_MIN;
    else
      sat = shifted[15:0];
  end

endmodule

// File: rtl/psola_playback.sv
// Ping-pong output buffer owner: accepts finished PSOLA frames and streams them one word per tick.
// Define PSOLA_PLAYBACK_CLEAR_EN to zero each word as it is consumed.
//
// state  | meaning
// IDLE   | waiting for an audio tick
// ADDR   | read address {play, idx} presented to the BRAM
// WAIT1  | BRAM read pipeline, first stage
// WAIT2  | BRAM data valid, captured at the end of this cycle
// EMIT   | renormalised sample on sample_out, idx advances
module psola_playback
  import psola_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [11:0]         window_len_in,
  input  logic                window_len_valid_in,
  input  logic                sample_tick_in,
  output logic                fill_bank_out,
  psola_playback_if.master    bram,
  output logic [15:0]         sample_out,
  output logic                sample_valid_out,
  output logic                underrun_out,
  output logic                overflow_out
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  play_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic              play_q, fill_q;
  logic [1:0]        full_q;
  logic [LEN_W-1:0]  len_q [2];
  logic [31:0]       data_q;
  logic              silence_q, drop_q, ovf_q;

  logic              emit, last, fill_free, frame_ok, accept, reject, tick_idle;
  logic signed [15:0] sat_sample;

  q_sat_shift #(.SHIFT(FRAC_BITS)) u_sat (
    .acc (data_q),
    .sat (sat_sample)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (sample_tick_in && full_q[play_q]) state_d = ST_ADDR;
      ST_ADDR:  state_d = ST_WAIT1;
      ST_WAIT1: state_d = ST_WAIT2;
      ST_WAIT2: state_d = ST_EMIT;
      ST_EMIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    emit      = (state_q == ST_EMIT);
    last      = emit && ({1'b0, idx_q} == (len_q[play_q] - LEN_ONE));
    // A bank finishing playback this cycle counts as free for an arriving frame.
    fill_free = !full_q[fill_q] || (last && (play_q == fill_q));
    frame_ok  = window_len_valid_in && (window_len_in != '0);
    accept    = frame_ok && fill_free;
    reject    = frame_ok && !fill_free;
    tick_idle = sample_tick_in && (state_q == ST_IDLE);

    sample_valid_out = emit || silence_q;
    sample_out       = emit ? sat_sample : '0;
    underrun_out     = silence_q || drop_q;
    overflow_out     = ovf_q;
    fill_bank_out    = fill_q;
    bram.rd_addr_out = (state_q != ST_IDLE) ? {play_q, idx_q} : '0;
`ifdef PSOLA_PLAYBACK_CLEAR_EN
    bram.clr_we_out   = emit;
    bram.clr_addr_out = emit ? {play_q, idx_q} : '0;
`else
    bram.clr_we_out   = 1'b0;
    bram.clr_addr_out = '0;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_q     <= '0;
      play_q    <= 1'b0;
      fill_q    <= 1'b0;
      full_q    <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      data_q    <= '0;
      silence_q <= 1'b0;
      drop_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      silence_q <= tick_idle && !full_q[play_q];
      drop_q    <= sample_tick_in && (state_q != ST_IDLE);
      ovf_q     <= reject;
      if (state_q == ST_WAIT2)
        data_q <= bram.rd_data_in;
      if (last) begin
        full_q[play_q] <= 1'b0;
        play_q         <= ~play_q;
        idx_q          <= '0;
      end else if (emit) begin
        idx_q <= idx_q + IDX_ONE;
      end
      // Placed after the release above so a refill of the bank being emptied wins.
      if (accept) begin
        full_q[fill_q] <= 1'b1;
        len_q[fill_q]  <= LEN_W'(window_len_in);
        fill_q         <= ~fill_q;
      end
    end
  end

endmodule
